// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream test packet generator: numbered packets of programmable length, count and gap.
// Define AXI4_STREAM_PKT_GEN_STATS_EN to add saturating word/packet/stall counters.
module axi4_stream_pkt_gen #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1,
   parameter int ID_WIDTH   = 1,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    stop_i,
   input  logic [LEN_WIDTH-1:0]    pkt_len_i,
   input  logic [LEN_WIDTH-1:0]    pkt_num_i,
   input  logic [LEN_WIDTH-1:0]    gap_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    pkt_tvalid_o,
   input  logic                    pkt_tready_i,
   output logic [DATA_WIDTH-1:0]   pkt_tdata_o,
   output logic [DATA_WIDTH/8-1:0] pkt_tkeep_o,
   output logic [DATA_WIDTH/8-1:0] pkt_tstrb_o,
   output logic                    pkt_tlast_o,
   output logic [USER_WIDTH-1:0]   pkt_tuser_o,
   output logic [ID_WIDTH-1:0]     pkt_tid_o,
   output logic [DEST_WIDTH-1:0]   pkt_tdest_o
`ifdef AXI4_STREAM_PKT_GEN_STATS_EN
   ,
   output logic [31:0]             words_sent_o,
   output logic [31:0]             pkts_sent_o,
   output logic [31:0]             stall_cnt_o
`endif
);

   localparam logic [LEN_WIDTH-1:0] LenOne = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t               state_q;
   logic [LEN_WIDTH-1:0] len_q, num_q, gap_q, widx_q, pidx_q, gapCnt_q;
   logic                 tvalid_q, busy_q, stopPend_q;
   logic                 handshake, lastBeat, stopReq, runEnd, done_d;
   logic [31:0]          beatWord;

   // A stop seen at any point of a run (even the start cycle) is remembered until the run ends.
   assign handshake = tvalid_q && pkt_tready_i;
   assign lastBeat  = (widx_q == len_q - LenOne);
   assign stopReq   = stop_i || stopPend_q;
   assign runEnd    = ((num_q != '0) && (pidx_q + LenOne == num_q)) || stopReq;
   assign done_d    = ((state_q == SEND) && handshake && lastBeat && runEnd) ||
                      ((state_q == GAP) && stopReq);

   assign beatWord     = {16'(pidx_q), 16'(widx_q)};
   assign pkt_tvalid_o = tvalid_q;
   assign pkt_tdata_o  = DATA_WIDTH'(beatWord);
   assign pkt_tkeep_o  = '1;
   assign pkt_tstrb_o  = '1;
   assign pkt_tlast_o  = lastBeat;
   assign pkt_tuser_o  = USER_WIDTH'(widx_q == '0);
   assign pkt_tid_o    = ID_WIDTH'(pidx_q);
   assign pkt_tdest_o  = '0;
   assign busy_o       = busy_q;
   assign done_o       = done_d;

   // Main FSM; tvalid only drops on a tlast handshake, so payload holds through stalls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         len_q      <= '0;
         num_q      <= '0;
         gap_q      <= '0;
         widx_q     <= '0;
         pidx_q     <= '0;
         gapCnt_q   <= '0;
         tvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
         stopPend_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  len_q      <= (pkt_len_i == '0) ? LenOne : pkt_len_i;
                  num_q      <= pkt_num_i;
                  gap_q      <= gap_i;
                  widx_q     <= '0;
                  pidx_q     <= '0;
                  gapCnt_q   <= '0;
                  stopPend_q <= stop_i;
                  tvalid_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (stop_i) stopPend_q <= 1'b1;
               if (handshake) begin
                  if (lastBeat) begin
                     widx_q <= '0;
                     pidx_q <= pidx_q + LenOne;
                     if (runEnd) begin
                        state_q    <= IDLE;
                        tvalid_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        stopPend_q <= 1'b0;
                     end else if (gap_q != '0) begin
                        state_q  <= GAP;
                        tvalid_q <= 1'b0;
                        gapCnt_q <= '0;
                     end
                  end else begin
                     widx_q <= widx_q + LenOne;
                  end
               end
            end
            GAP: begin
               if (stopReq) begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  stopPend_q <= 1'b0;
               end else if (gapCnt_q == gap_q - LenOne) begin
                  state_q  <= SEND;
                  tvalid_q <= 1'b1;
               end else begin
                  gapCnt_q <= gapCnt_q + LenOne;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef AXI4_STREAM_PKT_GEN_STATS_EN
   logic [31:0] words_q, pkts_q, stalls_q;

   // Run statistics, cleared by each accepted start and saturating rather than wrapping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         words_q  <= '0;
         pkts_q   <= '0;
         stalls_q <= '0;
      end else if ((state_q == IDLE) && start_i) begin
         words_q  <= '0;
         pkts_q   <= '0;
         stalls_q <= '0;
      end else begin
         if (handshake && (words_q != '1)) words_q <= words_q + 32'd1;
         if (handshake && lastBeat && (pkts_q != '1)) pkts_q <= pkts_q + 32'd1;
         if (tvalid_q && !pkt_tready_i && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
      end
   end

   assign words_sent_o = words_q;
   assign pkts_sent_o  = pkts_q;
   assign stall_cnt_o  = stalls_q;
`endif

endmodule

// File: tb/tb_axi4_stream_pkt_gen.sv
// Scoreboard bench for axi4_stream_pkt_gen: packet model fills a queue, a monitor pops on handshakes.
module tb_axi4_stream_pkt_gen;

   logic        clk = 1'b0;
   logic        rst_i, start_i, stop_i;
   logic [15:0] pkt_len_i, pkt_num_i, gap_i;
   logic        busy_o, done_o;
   logic        tvalid, tready, tlast;
   logic [31:0] tdata;
   logic [3:0]  tkeep, tstrb;
   logic [0:0]  tuser, tid, tdest;
`ifdef AXI4_STREAM_PKT_GEN_STATS_EN
   logic [31:0] wordsSent, pktsSent, stallCnt;
`endif

   always #5 clk = ~clk;

   axi4_stream_pkt_gen dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
      .pkt_len_i(pkt_len_i), .pkt_num_i(pkt_num_i), .gap_i(gap_i),
      .busy_o(busy_o), .done_o(done_o),
      .pkt_tvalid_o(tvalid), .pkt_tready_i(tready), .pkt_tdata_o(tdata),
      .pkt_tkeep_o(tkeep), .pkt_tstrb_o(tstrb), .pkt_tlast_o(tlast),
      .pkt_tuser_o(tuser), .pkt_tid_o(tid), .pkt_tdest_o(tdest)
`ifdef AXI4_STREAM_PKT_GEN_STATS_EN
      , .words_sent_o(wordsSent), .pkts_sent_o(pktsSent), .stall_cnt_o(stallCnt)
`endif
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        user;
      logic        id;
      logic        dest;
   } beat_t;

   beat_t expQ[$];
   int    checks = 0, errors = 0;
   int    cycleCount = 0, beatCount = 0, stallSeen = 0;
   int    firstValidCycle = -1, doneCycle = -1, startCycle = 0;
   bit    doneSeen = 1'b0;
   int    readyMode = 0, readyPhase = 0;
   bit    holdValid = 1'b0;
   beat_t heldBeat;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: packet p, word w carries {p, w}; tlast on the final word, tuser on the first.
   function automatic void pushPacket(input int p, input int len);
      int    effLen;
      beat_t b;
      effLen = (len == 0) ? 1 : len;
      for (int w = 0; w < effLen; w++) begin
         b.data = {p[15:0], w[15:0]};
         b.last = (w == effLen - 1);
         b.user = (w == 0);
         b.id   = p[0];
         b.dest = 1'b0;
         expQ.push_back(b);
      end
   endfunction

   // tready pattern changes just after the clock edge so the monitor sees a settled value.
   always @(posedge clk) begin
      #1;
      case (readyMode)
         0: tready = 1'b1;
         1: tready = 1'($urandom_range(0, 1));
         2: tready = 1'b0;
         default: begin
            tready = (readyPhase % 3 == 0);
            readyPhase++;
         end
      endcase
   end

   // Monitor: checks AXI hold rules and pops the scoreboard on every handshake.
   always @(negedge clk) begin
      beat_t act;
      beat_t exp;
      cycleCount++;
      if (rst_i) begin
         holdValid = 1'b0;
      end else begin
         act.data = tdata;
         act.last = tlast;
         act.user = tuser[0];
         act.id   = tid[0];
         act.dest = tdest[0];
         if (holdValid) begin
            checkOutput("tvalidHeld", 64'(tvalid), 64'd1);
            checkOutput("payloadHeld", 64'(act), 64'(heldBeat));
         end
         if (tvalid && firstValidCycle < 0) firstValidCycle = cycleCount;
         if (tvalid && !tready) begin
            stallSeen++;
            holdValid = 1'b1;
            heldBeat  = act;
         end else begin
            holdValid = 1'b0;
         end
         if (tvalid && tready) begin
            beatCount++;
            checkOutput("tkeepStrb", 64'({tkeep, tstrb}), 64'hFF);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedBeat: got 0x%0h, expected no beat", act);
            end else begin
               exp = expQ.pop_front();
               checkOutput("beatPayload", 64'(act), 64'(exp));
            end
         end
         if (done_o) begin
            doneSeen  = 1'b1;
            doneCycle = cycleCount;
            checkOutput("doneOnLastBeat", 64'({tvalid && tready, tlast}), 64'd3);
            checkOutput("queueEmptyAtDone", 64'(expQ.size()), 64'd0);
            checkOutput("busyAtDone", 64'(busy_o), 64'd1);
         end
      end
   end

   task automatic applyStimulus(input int len, input int num, input int gap, input int mode, input int nExp);
      readyMode  = mode;
      readyPhase = 0;
      for (int p = 0; p < nExp; p++) pushPacket(p, len);
      beatCount       = 0;
      stallSeen       = 0;
      firstValidCycle = -1;
      doneSeen        = 1'b0;
      pkt_len_i       = 16'(len);
      pkt_num_i       = 16'(num);
      gap_i           = 16'(gap);
      start_i         = 1'b1;
      startCycle      = cycleCount;
      @(negedge clk); #1;
      start_i = 1'b0;
      checkOutput("startLatency", 64'(firstValidCycle), 64'(startCycle + 1));
   endtask

   task automatic waitDone();
      for (int i = 0; i < 3000 && !doneSeen; i++) begin
         @(negedge clk); #1;
      end
      checkOutput("doneReached", 64'(doneSeen), 64'd1);
      @(negedge clk); #1;
      checkOutput("busyAfterDone", 64'(busy_o), 64'd0);
   endtask

   task automatic checkRunCycles(input int len, input int num, input int gap);
      int effLen;
      effLen = (len == 0) ? 1 : len;
      checkOutput("runCycles", 64'(doneCycle - firstValidCycle + 1), 64'(num * effLen + (num - 1) * gap));
   endtask

   task automatic checkStats(input int words, input int pkts);
`ifdef AXI4_STREAM_PKT_GEN_STATS_EN
      checkOutput("wordsSent", 64'(wordsSent), 64'(words));
      checkOutput("pktsSent", 64'(pktsSent), 64'(pkts));
      checkOutput("stallCnt", 64'(stallCnt), 64'(stallSeen));
`else
      if (words < 0 || pkts < 0) $display("[TB] negative stats request ignored");
`endif
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int len, num, gap, effLen;
      rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; tready = 1'b1;
      pkt_len_i = '0; pkt_num_i = '0; gap_i = '0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("resetTvalid", 64'(tvalid), 64'd0);
      checkOutput("resetBusy", 64'(busy_o), 64'd0);
      checkOutput("resetDone", 64'(done_o), 64'd0);
      rst_i = 1'b0;
      @(negedge clk); #1;

      $display("[TB] back-to-back packets, len=4 num=2");
      applyStimulus(4, 2, 0, 0, 2);
      waitDone();
      checkRunCycles(4, 2, 0);
      checkStats(8, 2);

      $display("[TB] gapped packets, len=3 num=2 gap=2");
      applyStimulus(3, 2, 2, 0, 2);
      waitDone();
      checkRunCycles(3, 2, 2);
      checkStats(6, 2);

      $display("[TB] backpressure pattern, len=5");
      applyStimulus(5, 1, 0, 3, 1);
      waitDone();
      checkStats(5, 1);

      $display("[TB] continuous mode stopped mid-packet");
      applyStimulus(2, 0, 0, 1, 3);
      for (int i = 0; i < 3000 && beatCount < 5; i++) begin
         @(negedge clk); #1;
      end
      checkOutput("stopPointReached", 64'(beatCount), 64'd5);
      stop_i = 1'b1;
      waitDone();
      stop_i = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checkOutput("idleAfterStop", 64'(tvalid), 64'd0);
      checkStats(6, 3);

      $display("[TB] zero length, start while busy ignored");
      applyStimulus(0, 1, 0, 2, 1);
      repeat (2) @(negedge clk);
      #1;
      start_i = 1'b1;
      @(negedge clk); #1;
      start_i   = 1'b0;
      readyMode = 0;
      waitDone();
      repeat (10) @(negedge clk);
      #1;
      checkOutput("startIgnoredBusy", 64'(busy_o), 64'd0);
      checkStats(1, 1);

      $display("[TB] simultaneous start and stop");
      stop_i = 1'b1;
      applyStimulus(3, 0, 1, 1, 1);
      stop_i = 1'b0;
      waitDone();
      repeat (5) @(negedge clk);
      #1;
      checkStats(3, 1);

      $display("[TB] reset in the middle of a packet");
      applyStimulus(10, 1, 0, 0, 1);
      for (int i = 0; i < 3000 && beatCount < 3; i++) begin
         @(negedge clk); #1;
      end
      #2;
      rst_i = 1'b1;
      #1;
      checkOutput("asyncResetTvalid", 64'(tvalid), 64'd0);
      checkOutput("asyncResetBusy", 64'(busy_o), 64'd0);
      expQ.delete();
      @(negedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk); #1;
      applyStimulus(2, 1, 0, 0, 1);
      waitDone();
      checkStats(2, 1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 6; r++) begin
         len    = $urandom_range(0, 6);
         num    = $urandom_range(1, 3);
         gap    = $urandom_range(0, 3);
         effLen = (len == 0) ? 1 : len;
         applyStimulus(len, num, gap, 1, num);
         waitDone();
         checkStats(effLen * num, num);
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi4_stream_pkt_gen.md
Name: axi4_stream_pkt_gen

Overview:
- AXI4-Stream packet transmitter. Produces numbered test packets of programmable length, count and inter-packet gap.
- Sits upstream of the packet FIFO and other stream sinks. Used as a traffic source in benches and in on-chip loopback/self-test paths.
- Fully honours tready backpressure. Every packet is emitted whole; there is no truncation.

Parameters:
- DATA_WIDTH, 32, tdata width in bits. Must be >= 32 and a multiple of 8.
- USER_WIDTH, 1, tuser width.
- DEST_WIDTH, 1, tdest width.
- ID_WIDTH, 1, tid width.
- LEN_WIDTH, 16, width of the packet length, count and gap fields.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle start request; ignored while busy_o=1
- stop_i  in  1  level; finish the current packet, then return to IDLE
- pkt_len_i  in  LEN_WIDTH  words per packet, sampled on start; 0 is treated as 1
- pkt_num_i  in  LEN_WIDTH  packets to send, sampled on start; 0 means continuous until stop_i
- gap_i  in  LEN_WIDTH  idle cycles between packets, sampled on start
- busy_o  out  1  high from the accepted start until the last tlast handshake (plus gap)
- done_o  out  1  one-cycle pulse when the run completes
- pkt_o  axi4_stream_if.master  -  generated stream

Behaviour:
- Reset values: tvalid=0, busy_o=0, done_o=0, all counters 0, state IDLE.
- Reset mid-packet aborts immediately with tvalid=0. No tlast is emitted; the downstream sink is expected to tolerate this.
- States: IDLE, SEND, GAP.
- IDLE -> SEND: start_i=1. Length, count and gap are latched. Word index (widx) and packet index (pidx) are cleared. tvalid rises the next cycle, so latency is 1 clock.
- SEND: tvalid=1 continuously; there are no bubbles inside a packet. widx increments on each handshake (tvalid && tready).
- Handshake with widx == len-1 (tlast=1) leaves SEND. pidx increments on that handshake. Next state:
  - IDLE, with done_o pulsed the same clock, if pidx+1 == num (num != 0) or stop_i=1;
  - otherwise GAP if gap != 0;
  - otherwise SEND, giving back-to-back packets with tvalid held high.
- GAP: tvalid=0. Counts gap cycles, then enters SEND. stop_i sampled high in GAP -> IDLE with done_o.
- AXI rule: once tvalid=1, tvalid and all payload fields hold stable until the handshake. A change on stop_i never deasserts tvalid.
- Payload fields:
  - tdata[31:16] = pidx[15:0], tdata[15:0] = widx[15:0]; upper tdata bits are 0.
  - tkeep and tstrb are all ones. tlast is high on widx == len-1.
  - tuser[0] = (widx == 0), i.e. start-of-frame; other tuser bits are 0.
  - tid = pidx modulo 2^ID_WIDTH. tdest = 0.
- Arithmetic: widx and pidx are LEN_WIDTH wide and wrap modulo 2^LEN_WIDTH. In continuous mode pidx wraps silently.
- busy_o=1 in SEND and GAP.
- Simultaneous start_i and stop_i in IDLE: start wins and exactly one packet is sent.
- tready held low indefinitely leaves the state frozen. There is no timeout.

Optional Feature:
- Macro: AXI4_STREAM_PKT_GEN_STATS_EN.
- When defined, adds three outputs, each 32 bits, saturating at all ones, cleared on reset and on an accepted start_i:
  - words_sent_o: handshake count;
  - pkts_sent_o: tlast handshake count;
  - stall_cnt_o: cycles with tvalid && !tready.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- len=4, num=2, gap=0, tready=1 -> 8 consecutive beats. tdata = 0x00000000..0x00000003, then 0x00010000..0x00010003. tlast on beats 4 and 8, tuser on beats 1 and 5. done_o pulses in the clock of beat 8; busy_o falls the next clock.
- len=3, num=2, gap=2 -> beat, beat, beat(last), 2 cycles with tvalid=0, then 3 beats. Total 8 clocks from the first tvalid to done_o.
- len=5, tready toggling 1,0,0,1,... -> payload stable during every stall. 5 beats total. With STATS_EN, stall_cnt_o equals the number of low-tready valid cycles and words_sent_o=5.
- num=0 (continuous), len=2; assert stop_i mid-packet -> that packet completes with tlast, done_o pulses, no further tvalid. pkts_sent_o equals the tlast count.
- len=0, num=1 -> a single beat with tlast=1 and tuser=1, tdata=0. A start_i pulse while busy is ignored.
- rst_i asserted mid-SEND -> tvalid=0 and busy_o=0 asynchronously. After release, a start gives a fresh run with pidx=0.
